// File: rtl/ring_pattern_pkg.sv
// rtl/ring_pattern_pkg.sv - shared mode encodings and helpers for the ring pattern counter
package ring_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_RING    = 2'b00,
        MODE_JOHNSON = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_t;

    // Callers zero-extend narrower patterns; zero-extension never changes one-hotness.
    function automatic logic is_onehot32(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider producing a registered one-cycle step-rate pulse
module tick_gen #(
    parameter int DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    // tick is registered from the terminal count, so the first pulse lands DIV cycles after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (div_cnt == LAST);
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ring_pattern_counter.sv
// rtl/ring_pattern_counter.sv - ring / Johnson / bounce pattern generator stepped by a divided tick
module ring_pattern_counter
    import ring_pattern_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] INIT = {1'b1, {(WIDTH-1){1'b0}}};

    mode_t            mode_q;
    logic             step;
    logic             onehot;
    logic             up;
    logic             next_up;
    logic [WIDTH-1:0] next_count;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign mode_q = mode_t'(mode);
    assign step   = tick & en & (mode_q != MODE_HOLD) & ~load;
    assign onehot = is_onehot32(32'(count));

    always_comb begin
        next_count = count;
        next_up    = up;
        case (mode_q)
            MODE_RING: begin
                if (!onehot) begin
                    next_count = INIT;
                    next_up    = 1'b0;
                end else if (dir) begin
                    next_count = {count[0], count[WIDTH-1:1]};
                end else begin
                    next_count = {count[WIDTH-2:0], count[WIDTH-1]};
                end
            end
            MODE_JOHNSON: begin
                if (dir) begin
                    next_count = {~count[0], count[WIDTH-1:1]};
                end else begin
                    next_count = {count[WIDTH-2:0], ~count[WIDTH-1]};
                end
            end
            MODE_BOUNCE: begin
                if (!onehot) begin
                    next_count = INIT;
                    next_up    = 1'b0;
                end else begin
                    // Direction flips at either end before the shift, so the end bits are visited once.
                    if (count[WIDTH-1]) begin
                        next_up = 1'b0;
                    end else if (count[0]) begin
                        next_up = 1'b1;
                    end
                    next_count = next_up ? (count << 1) : (count >> 1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= INIT;
            up    <= 1'b0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_val;
            wrap  <= 1'b0;
        end else if (step) begin
            count <= next_count;
            up    <= next_up;
            wrap  <= (next_count == INIT);
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ring_pattern_counter.sv
// tb/tb_ring_pattern_counter.sv - randomized model-checked bench for ring_pattern_counter
module tb_ring_pattern_counter;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         dir = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         tick;
    logic         wrap;

    always #5 clk = ~clk;

    ring_pattern_counter #(
        .WIDTH (W),
        .DIV   (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tick     (tick),
        .wrap     (wrap)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int bitpos(input int c);
        int p;
        int ones;
        p = -1;
        ones = 0;
        for (int i = 0; i < W; i++) begin
            if (((c >> i) & 1) == 1) begin
                p = i;
                ones++;
            end
        end
        return (ones == 1) ? p : -1;
    endfunction

    // Reference model: cycle count since reset drives the tick, patterns via arithmetic.
    int m_count = 128;
    int m_tick  = 0;
    int m_wrap  = 0;
    int m_up    = 0;
    int m_cyc   = 0;
    bit model_ok = 1'b0;
    int nc;
    int p;
    bit stp;

    always @(posedge clk) begin
        if (!rst) begin
            m_count = 128;
            m_tick  = 0;
            m_wrap  = 0;
            m_up    = 0;
            m_cyc   = 0;
            model_ok = 1'b1;
        end else begin
            stp = (m_tick == 1) && en && (mode != 2'd3) && !load;
            nc  = m_count;
            if (load) begin
                m_count = int'(load_val);
                m_wrap  = 0;
            end else if (stp) begin
                case (mode)
                    2'd0: begin
                        if (bitpos(m_count) < 0) begin
                            nc = 128;
                            m_up = 0;
                        end else if (dir) nc = m_count / 2 + (m_count % 2) * 128;
                        else nc = (m_count * 2) % 256 + m_count / 128;
                    end
                    2'd1: begin
                        if (dir) nc = m_count / 2 + (1 - m_count % 2) * 128;
                        else nc = (m_count * 2) % 256 + (1 - m_count / 128);
                    end
                    default: begin
                        p = bitpos(m_count);
                        if (p < 0) begin
                            nc = 128;
                            m_up = 0;
                        end else begin
                            if (p == W - 1) m_up = 0;
                            else if (p == 0) m_up = 1;
                            p = (m_up == 1) ? p + 1 : p - 1;
                            nc = 1 << p;
                        end
                    end
                endcase
                m_count = nc;
                m_wrap  = (nc == 128) ? 1 : 0;
            end else begin
                m_wrap = 0;
            end
            m_cyc++;
            m_tick = (m_cyc % D == 0) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("count", int'(count), m_count);
            check("tick", int'(tick), m_tick);
            check("wrap", int'(wrap), m_wrap);
        end
    end

    task automatic do_reset(input logic [1:0] m);
        rst  = 1'b0;
        mode = m;
        dir  = 1'b0;
        en   = 1'b1;
        load = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    int first;
    int ticks;
    int held;
    bit done;

    initial begin
        do_reset(2'd0);
        check("rst_count", int'(count), 'h80);
        check("rst_tick", int'(tick), 0);
        check("rst_wrap", int'(wrap), 0);
        for (int e = 1; e <= 33; e++) begin
            @(negedge clk);
            if (e == 4)  check("first_tick", int'(tick), 1);
            if (e == 5)  check("ring_s1", int'(count), 'h01);
            if (e == 9)  check("ring_s2", int'(count), 'h02);
            if (e == 13) check("ring_s3", int'(count), 'h04);
            if (e == 33) begin
                check("ring_back", int'(count), 'h80);
                check("ring_wrap", int'(wrap), 1);
            end
        end

        do_reset(2'd1);
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            if (e == 5) check("john_s1", int'(count), 'h00);
            if (e == 9) check("john_s2", int'(count), 'h01);
        end
        rst      = 1'b0;
        load     = 1'b1;
        load_val = 8'h3C;
        @(negedge clk);
        check("rst_over_load", int'(count), 'h80);
        check("rst_over_wrap", int'(wrap), 0);
        rst  = 1'b1;
        load = 1'b0;
        first = 0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (tick && first == 0) first = e;
        end
        check("tick_after_release", first, 4);

        do_reset(2'd2);
        repeat (5) @(negedge clk);
        check("bounce_s1", int'(count), 'h40);
        repeat (60) @(negedge clk);

        mode     = 2'd0;
        load     = 1'b1;
        load_val = 8'hA5;
        @(negedge clk);
        load = 1'b0;
        check("load_a5", int'(count), 'hA5);
        check("load_nowrap", int'(wrap), 0);
        done = 1'b0;
        for (int e = 0; e < 8 && !done; e++) begin
            @(negedge clk);
            if (count != 8'hA5) done = 1'b1;
        end
        check("correct_done", int'(done), 1);
        check("correct_count", int'(count), 'h80);
        check("correct_wrap", int'(wrap), 1);

        done = 1'b0;
        for (int e = 0; e < 8 && !done; e++) begin
            @(negedge clk);
            if (tick) done = 1'b1;
        end
        load     = 1'b1;
        load_val = 8'h10;
        @(negedge clk);
        load = 1'b0;
        check("load_on_tick", int'(count), 'h10);

        mode  = 2'd3;
        held  = m_count;
        ticks = 0;
        repeat (12) begin
            @(negedge clk);
            ticks += int'(tick);
        end
        check("hold_count", int'(count), held);
        check("hold_ticks", ticks, 3);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            load     = ($urandom_range(0, 31) == 0);
            load_val = 8'($urandom);
            rst      = ($urandom_range(0, 255) != 0);
        end
        rst = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
